// File: rtl/rx_threshold_trainer.sv
// RX threshold training controller.
// Sends a PRBS7 stream into the channel and steps the detector threshold from THR_STEP
// upward. At each step it counts bit errors, then programs the midpoint of the
// minimum-error window.
module rx_threshold_trainer #(
    parameter int unsigned NUMBER_OF_LEVELS = 256,
    parameter int unsigned THR_STEP         = 16,
    parameter int unsigned BITS_PER_STEP    = 64,
    parameter int unsigned LAT              = 4,
    parameter int unsigned ERR_LIMIT        = 0
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic                                 rx_bit,
    output logic                                 tx_bit,
    output logic [$clog2(NUMBER_OF_LEVELS)-1:0]  threshold,
    output logic                                 busy,
    output logic                                 done,
    output logic [$clog2(BITS_PER_STEP+1)-1:0]   best_errors,
    output logic                                 lock_fail
);

    localparam int unsigned TW = $clog2(NUMBER_OF_LEVELS);
    localparam int unsigned EW = $clog2(BITS_PER_STEP + 1);
    // One counter serves both the flush (LAT+1 cycles) and measure (BITS_PER_STEP cycles) phases
    localparam int unsigned CW = $clog2((BITS_PER_STEP > LAT + 1) ? BITS_PER_STEP : LAT + 1);

    localparam logic [TW-1:0] THR_RESET  = TW'(NUMBER_OF_LEVELS / 2);
    localparam logic [TW-1:0] THR_FIRST  = TW'(THR_STEP);
    localparam logic [TW:0]   THR_STEP_W = (TW + 1)'(THR_STEP);
    localparam logic [TW:0]   THR_MAX_W  = (TW + 1)'(NUMBER_OF_LEVELS - 1);
    localparam logic [CW-1:0] FLUSH_LAST = CW'(LAT);
    localparam logic [CW-1:0] MEAS_LAST  = CW'(BITS_PER_STEP - 1);
    localparam logic [6:0]    PRBS_SEED  = 7'h7F;

    typedef enum logic [2:0] {
        StIdle,
        StFlush,
        StMeasure,
        StEval,
        StDone
    } state_e;

    state_e          state_q;
    logic [6:0]      prbs_q;
    logic [CW-1:0]   cnt_q;
    logic [EW-1:0]   err_q;
    logic [TW-1:0]   lo_q;
    logic [TW-1:0]   hi_q;
    logic [LAT-1:0]  ref_q;

    logic [6:0]      prbs_next;
    logic            mismatch;
    logic [EW-1:0]   err_inc;
    logic [TW:0]     thr_next_w;
    logic            last_step;
    logic [EW-1:0]   best_n;
    logic [TW-1:0]   lo_n;
    logic [TW-1:0]   hi_n;
    logic [TW:0]     mid_sum;

    // Step arithmetic and the result of evaluating the current step's error count
    always_comb begin
        prbs_next  = {prbs_q[5:0], prbs_q[6] ^ prbs_q[5]};
        mismatch   = rx_bit ^ ref_q[LAT-1];
        err_inc    = err_q + EW'(mismatch);
        // One bit wider so the last step is detected without wrapping
        thr_next_w = {1'b0, threshold} + THR_STEP_W;
        last_step  = thr_next_w > THR_MAX_W;

        best_n = best_errors;
        lo_n   = lo_q;
        hi_n   = hi_q;
        if (err_q < best_errors) begin
            best_n = err_q;
            lo_n   = threshold;
            hi_n   = threshold;
        end else if (err_q == best_errors) begin
            hi_n = threshold;
        end
        mid_sum = {1'b0, lo_n} + {1'b0, hi_n};
    end

    // Reference copy of tx_bit, aligned with the channel's LAT-cycle latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_q <= '0;
        end else begin
            ref_q[0] <= tx_bit;
            for (int i = 1; i < int'(LAT); i++) begin
                ref_q[i] <= ref_q[i-1];
            end
        end
    end

    // Training FSM with PRBS generator and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            prbs_q      <= PRBS_SEED;
            tx_bit      <= 1'b0;
            threshold   <= THR_RESET;
            busy        <= 1'b0;
            done        <= 1'b0;
            best_errors <= '1;
            lock_fail   <= 1'b0;
            cnt_q       <= '0;
            err_q       <= '0;
            lo_q        <= '0;
            hi_q        <= '0;
        end else begin
            done <= 1'b0;
            if (state_q != StIdle) begin
                prbs_q <= prbs_next;
                tx_bit <= prbs_next[6];
            end

            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q     <= StFlush;
                        busy        <= 1'b1;
                        prbs_q      <= PRBS_SEED;
                        tx_bit      <= PRBS_SEED[6];
                        threshold   <= THR_FIRST;
                        best_errors <= '1;
                        lo_q        <= '0;
                        hi_q        <= '0;
                        lock_fail   <= 1'b0;
                        cnt_q       <= '0;
                    end
                end
                StFlush: begin
                    if (cnt_q == FLUSH_LAST) begin
                        state_q <= StMeasure;
                        cnt_q   <= '0;
                        err_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                StMeasure: begin
                    err_q <= err_inc;
                    if (cnt_q == MEAS_LAST) begin
                        state_q <= StEval;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                StEval: begin
                    best_errors <= best_n;
                    lo_q        <= lo_n;
                    hi_q        <= hi_n;
                    // Results are published on entry to DONE so they are valid with the done pulse
                    if (last_step) begin
                        threshold <= TW'(mid_sum >> 1);
                        lock_fail <= 32'(best_n) > ERR_LIMIT;
                        done      <= 1'b1;
                        state_q   <= StDone;
                    end else begin
                        threshold <= thr_next_w[TW-1:0];
                        cnt_q     <= '0;
                        state_q   <= StFlush;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                    tx_bit  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_threshold_trainer.sv
// Directed bench for rx_threshold_trainer: a behavioural channel returns tx_bit delayed
// by 4 cycles, either correct or inverted depending on the threshold, or stuck at 0.
module tb_rx_threshold_trainer;

    localparam int RUN_CYCLES = 1051;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       rx_bit;
    logic       tx_bit;
    logic [7:0] threshold;
    logic       busy;
    logic       done;
    logic [6:0] best_errors;
    logic       lock_fail;

    int errors = 0;
    int checks = 0;

    // Channel behaviour: thresholds inside either good window pass bits, others invert
    int   g0_lo = 0, g0_hi = 255, g1_lo = 1, g1_hi = 0;
    bit   stuck0 = 1'b0;
    logic [3:0] chan = '0;
    logic good;

    typedef struct {
        string name;
        int    g0_lo;
        int    g0_hi;
        int    g1_lo;
        int    g1_hi;
        bit    stuck;
        int    thr;
        int    best;
        bit    lock;
    } vec_t;

    vec_t vecs[8];

    rx_threshold_trainer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .rx_bit      (rx_bit),
        .tx_bit      (tx_bit),
        .threshold   (threshold),
        .busy        (busy),
        .done        (done),
        .best_errors (best_errors),
        .lock_fail   (lock_fail)
    );

    always #5 clk = ~clk;

    always @(posedge clk) chan <= {chan[2:0], tx_bit};

    always_comb begin
        good = (int'(threshold) >= g0_lo && int'(threshold) <= g0_hi) ||
               (int'(threshold) >= g1_lo && int'(threshold) <= g1_hi);
        rx_bit = stuck0 ? 1'b0 : (chan[3] ^ ~good);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, " tx_bit"}, 32'(tx_bit), 0);
        check({tag, " threshold"}, 32'(threshold), 128);
        check({tag, " busy"}, 32'(busy), 0);
        check({tag, " done"}, 32'(done), 0);
        check({tag, " best_errors"}, 32'(best_errors), 127);
        check({tag, " lock_fail"}, 32'(lock_fail), 0);
    endtask

    // Pulse start in IDLE; returns the cycle index (1 = first cycle after the accept edge)
    // at which done is seen, and the first 8 tx bits, oldest in the MSB.
    task automatic run_once(output int cyc, output logic [7:0] txs);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        txs = {7'd0, tx_bit};
        while (done !== 1'b1 && cyc < RUN_CYCLES + 50) begin
            @(negedge clk);
            cyc++;
            if (cyc <= 8) txs = {txs[6:0], tx_bit};
        end
    endtask

    // Independent step model for the stuck-at-0 channel: errors = ones in each window
    function automatic void model_stuck(output int thr, output int best);
        bit         tx[0:RUN_CYCLES];
        logic [6:0] p;
        int         e, lo, hi, t;
        p = 7'h7F;
        tx[0] = 1'b0;
        for (int c = 1; c <= RUN_CYCLES; c++) begin
            tx[c] = p[6];
            p = {p[5:0], p[6] ^ p[5]};
        end
        best = 127;
        lo = 0;
        hi = 0;
        for (int k = 0; k < 15; k++) begin
            e = 0;
            for (int c = 70 * k + 6; c <= 70 * k + 69; c++) begin
                if (tx[c-4]) e++;
            end
            t = 16 * (k + 1);
            if (e < best) begin
                best = e;
                lo = t;
                hi = t;
            end else if (e == best) begin
                hi = t;
            end
        end
        thr = (lo + hi) >> 1;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         cyc;
        logic [7:0] txs;
        int         st_thr, st_best;

        model_stuck(st_thr, st_best);
        vecs[0] = '{"ideal",     0, 255,   1,   0, 1'b0, 128,  0, 1'b0};
        vecs[1] = '{"win96_160", 96, 160,  1,   0, 1'b0, 128,  0, 1'b0};
        vecs[2] = '{"win48_80",  48, 80,   1,   0, 1'b0, 64,   0, 1'b0};
        vecs[3] = '{"all_bad",   1,  0,    1,   0, 1'b0, 128, 64, 1'b1};
        vecs[4] = '{"gap32_208", 32, 32, 208, 208, 1'b0, 120,  0, 1'b0};
        vecs[5] = '{"top240",   240, 255,  1,   0, 1'b0, 240,  0, 1'b0};
        vecs[6] = '{"bottom16", 16,  16,   1,   0, 1'b0, 16,   0, 1'b0};
        vecs[7] = '{"stuck0",    0, 255,   1,   0, 1'b1, st_thr, st_best, 1'b1};

        repeat (3) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            g0_lo  = vecs[i].g0_lo;
            g0_hi  = vecs[i].g0_hi;
            g1_lo  = vecs[i].g1_lo;
            g1_hi  = vecs[i].g1_hi;
            stuck0 = vecs[i].stuck;
            run_once(cyc, txs);
            check({vecs[i].name, " done_cycle"}, 32'(cyc), RUN_CYCLES);
            check({vecs[i].name, " threshold"}, 32'(threshold), 32'(vecs[i].thr));
            check({vecs[i].name, " best_errors"}, 32'(best_errors), 32'(vecs[i].best));
            check({vecs[i].name, " lock_fail"}, 32'(lock_fail), 32'(vecs[i].lock));
            check({vecs[i].name, " busy_at_done"}, 32'(busy), 1);
            if (i == 0) check("first_run tx_seq", 32'(txs), 32'h0FE);
            @(negedge clk);
            check({vecs[i].name, " idle_busy"}, 32'(busy), 0);
            check({vecs[i].name, " done_pulse"}, 32'(done), 0);
            repeat (3) @(negedge clk);
            check({vecs[i].name, " thr_hold"}, 32'(threshold), 32'(vecs[i].thr));
        end

        // Reset in the middle of step 5's measurement window (cycles 286..349)
        g0_lo = 0; g0_hi = 255; g1_lo = 1; g1_hi = 0; stuck0 = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (299) @(negedge clk);
        check("midrun busy", 32'(busy), 1);
        check("midrun threshold", 32'(threshold), 80);
        #2 rst_n = 1'b0;
        #1 check_reset("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_once(cyc, txs);
        check("rerun done_cycle", 32'(cyc), RUN_CYCLES);
        check("rerun threshold", 32'(threshold), 128);
        check("rerun best_errors", 32'(best_errors), 0);
        check("rerun lock_fail", 32'(lock_fail), 0);
        check("rerun tx_seq", 32'(txs), 32'h0FE);
        repeat (2) @(negedge clk);

        // start held high: one pass, ignored in DONE, restart from the next IDLE cycle
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        cyc = 1;
        while (done !== 1'b1 && cyc < RUN_CYCLES + 50) begin
            @(negedge clk);
            cyc++;
        end
        check("held done_cycle", 32'(cyc), RUN_CYCLES);
        check("held threshold", 32'(threshold), 128);
        @(negedge clk);
        check("held idle_busy", 32'(busy), 0);
        @(negedge clk);
        check("held restart_busy", 32'(busy), 1);
        check("held restart_tx", 32'(tx_bit), 1);
        check("held restart_thr", 32'(threshold), 16);
        start = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < RUN_CYCLES + 50) begin
            @(negedge clk);
            cyc++;
        end
        check("held second done_cycle", 32'(cyc), RUN_CYCLES);
        @(negedge clk);
        check("held second idle", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
